// File: rtl/i2c_sensor_secondary.sv
// I2C target standing in for an on-tag sensor: oversampled START/STOP decode,
// auto-incrementing register pointer, register 0 holds the latest core sample.
`timescale 1ns/1ps
module i2c_sensor_secondary #(
   parameter logic [6:0] I2C_ADDR    = 7'h48,
   parameter int         NUM_REGS    = 8,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] REG_INIT    = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   input  logic [7:0] sensor_data,
   input  logic       sensor_valid,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);
   localparam int PW = $clog2(NUM_REGS);

   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] ADDR      = 4'd1;
   localparam logic [3:0] ADDR_ACK  = 4'd2;
   localparam logic [3:0] PTR       = 4'd3;
   localparam logic [3:0] PTR_ACK   = 4'd4;
   localparam logic [3:0] WDATA     = 4'd5;
   localparam logic [3:0] WDATA_ACK = 4'd6;
   localparam logic [3:0] RDATA     = 4'd7;
   localparam logic [3:0] RDATA_ACK = 4'd8;

   logic [SYNC_STAGES-1:0] sclSync_q, sdaSync_q;
   logic                   sclPrev_q, sdaPrev_q;
   logic                   sclS, sdaS, sclRise, sclFall, startDet, stopDet;
   logic [3:0]             state_q, state_d;
   logic [3:0]             bitCnt_q, bitCnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   sdaOe_q, sdaOe_d;
   logic                   busy_q, busy_d;
   logic                   rw_q, rw_d;
   logic                   wrStrobe_q, wrStrobe_d;
   logic [7:0]             wrAddr_q, wrAddr_d;
   logic [7:0]             wrData_q, wrData_d;
   logic [PW-1:0]          ptr_q, ptr_d, ptrNext;
   logic [7:0]             regs_q [NUM_REGS];
   logic [7:0]             rxByte, readByte;
   logic                   regWe;

   // Bus idles high, so the synchronisers reset to 1 to avoid a false START.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclSync_q <= '1;
         sdaSync_q <= '1;
         sclPrev_q <= 1'b1;
         sdaPrev_q <= 1'b1;
      end else begin
         sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_i};
         sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_i};
         sclPrev_q <= sclS;
         sdaPrev_q <= sdaS;
      end
   end

   assign sclS     = sclSync_q[SYNC_STAGES-1];
   assign sdaS     = sdaSync_q[SYNC_STAGES-1];
   assign sclRise  = sclS & ~sclPrev_q;
   assign sclFall  = ~sclS & sclPrev_q;
   assign startDet = sclS & sclPrev_q & sdaPrev_q & ~sdaS;
   assign stopDet  = sclS & sclPrev_q & ~sdaPrev_q & sdaS;

   assign rxByte   = {shift_q[6:0], sdaS};
   assign ptrNext  = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + PW'(1);
   // A sample arriving on the load cycle of register 0 wins over the stored value.
   assign readByte = (ptr_q == '0 && sensor_valid) ? sensor_data : regs_q[ptr_q];

   always_comb begin
      state_d    = state_q;
      bitCnt_d   = bitCnt_q;
      shift_d    = shift_q;
      sdaOe_d    = sdaOe_q;
      busy_d     = busy_q;
      rw_d       = rw_q;
      ptr_d      = ptr_q;
      wrStrobe_d = 1'b0;
      wrAddr_d   = wrAddr_q;
      wrData_d   = wrData_q;
      regWe      = 1'b0;
      if (startDet) begin
         state_d  = ADDR;
         bitCnt_d = 4'd0;
         sdaOe_d  = 1'b0;
      end else if (stopDet) begin
         state_d = IDLE;
         sdaOe_d = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ADDR: begin
               if (sclRise && bitCnt_q != 4'd8) begin
                  shift_d  = rxByte;
                  bitCnt_d = bitCnt_q + 4'd1;
               end else if (sclFall && bitCnt_q == 4'd8) begin
                  if (shift_q[7:1] == I2C_ADDR) begin
                     sdaOe_d = 1'b1;
                     busy_d  = 1'b1;
                     rw_d    = shift_q[0];
                     state_d = ADDR_ACK;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = IDLE;
                  end
               end
            end
            ADDR_ACK: begin
               if (sclFall) begin
                  bitCnt_d = 4'd0;
                  if (rw_q) begin
                     shift_d = readByte;
                     sdaOe_d = ~readByte[7];
                     state_d = RDATA;
                  end else begin
                     sdaOe_d = 1'b0;
                     state_d = PTR;
                  end
               end
            end
            PTR: begin
               if (sclRise && bitCnt_q != 4'd8) begin
                  shift_d  = rxByte;
                  bitCnt_d = bitCnt_q + 4'd1;
               end else if (sclFall && bitCnt_q == 4'd8) begin
                  if (int'(shift_q) < NUM_REGS) begin
                     ptr_d   = shift_q[PW-1:0];
                     sdaOe_d = 1'b1;
                     state_d = PTR_ACK;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            PTR_ACK, WDATA_ACK: begin
               if (sclFall) begin
                  sdaOe_d  = 1'b0;
                  bitCnt_d = 4'd0;
                  state_d  = WDATA;
               end
            end
            WDATA: begin
               if (sclRise && bitCnt_q != 4'd8) begin
                  shift_d  = rxByte;
                  bitCnt_d = bitCnt_q + 4'd1;
                  if (bitCnt_q == 4'd7) begin
                     wrStrobe_d = 1'b1;
                     wrAddr_d   = 8'(ptr_q);
                     wrData_d   = rxByte;
                     regWe      = (ptr_q != '0);
                     ptr_d      = ptrNext;
                  end
               end else if (sclFall && bitCnt_q == 4'd8) begin
                  sdaOe_d = 1'b1;
                  state_d = WDATA_ACK;
               end
            end
            RDATA: begin
               if (sclRise && bitCnt_q != 4'd8) begin
                  bitCnt_d = bitCnt_q + 4'd1;
               end else if (sclFall && bitCnt_q == 4'd8) begin
                  sdaOe_d = 1'b0;
                  ptr_d   = ptrNext;
                  state_d = RDATA_ACK;
               end else if (sclFall && bitCnt_q != 4'd0) begin
                  shift_d = {shift_q[6:0], 1'b0};
                  sdaOe_d = ~shift_q[6];
               end
            end
            RDATA_ACK: begin
               if (sclRise && sdaS) begin
                  state_d = IDLE;
               end else if (sclFall) begin
                  bitCnt_d = 4'd0;
                  shift_d  = readByte;
                  sdaOe_d  = ~readByte[7];
                  state_d  = RDATA;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bitCnt_q   <= 4'd0;
         shift_q    <= 8'h00;
         sdaOe_q    <= 1'b0;
         busy_q     <= 1'b0;
         rw_q       <= 1'b0;
         ptr_q      <= '0;
         wrStrobe_q <= 1'b0;
         wrAddr_q   <= 8'h00;
         wrData_q   <= 8'h00;
      end else begin
         state_q    <= state_d;
         bitCnt_q   <= bitCnt_d;
         shift_q    <= shift_d;
         sdaOe_q    <= sdaOe_d;
         busy_q     <= busy_d;
         rw_q       <= rw_d;
         ptr_q      <= ptr_d;
         wrStrobe_q <= wrStrobe_d;
         wrAddr_q   <= wrAddr_d;
         wrData_q   <= wrData_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= (i == 0) ? 8'h00 : REG_INIT;
         end
      end else begin
         if (sensor_valid) regs_q[0] <= sensor_data;
         if (regWe) regs_q[ptr_q] <= rxByte;
      end
   end

   assign sda_oe    = sdaOe_q;
   assign busy      = busy_q;
   assign wr_strobe = wrStrobe_q;
   assign wr_addr   = wrAddr_q;
   assign wr_data   = wrData_q;
endmodule

// File: tb/tb_i2c_sensor_secondary.sv
// Bench for i2c_sensor_secondary: bit-banged I2C primary on a wired-AND SDA,
// checked against a transaction-level register/pointer model.
`timescale 1ns/1ps
module tb_i2c_sensor_secondary;
   localparam int         NUM_REGS = 8;
   localparam logic [7:0] REG_INIT = 8'h5E;
   localparam int         Q        = 8;

   logic       clk, rst_n, sclM, sdaM, sdaLine;
   logic       sda_oe, wr_strobe, busy, sensor_valid;
   logic [7:0] sensor_data, wr_addr, wr_data;

   int         total, bad;
   int         oeCnt, strbCnt;
   logic [7:0] strbAddr [256];
   logic [7:0] strbData [256];
   logic [7:0] model [NUM_REGS];
   int         mPtr;

   assign sdaLine = sdaM & ~sda_oe;

   i2c_sensor_secondary #(
      .I2C_ADDR(7'h48), .NUM_REGS(NUM_REGS), .SYNC_STAGES(2), .REG_INIT(REG_INIT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .scl_i(sclM), .sda_i(sdaLine), .sda_oe(sda_oe),
      .sensor_data(sensor_data), .sensor_valid(sensor_valid), .wr_strobe(wr_strobe),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log every SDA drive cycle and every commit pulse seen by the bus side.
   always @(negedge clk) begin
      if (sda_oe) oeCnt++;
      if (wr_strobe) begin
         if (strbCnt < 256) begin
            strbAddr[strbCnt] = wr_addr;
            strbData[strbCnt] = wr_data;
         end
         strbCnt++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic scl, input logic sda);
      sclM = scl;
      sdaM = sda;
      repeat (Q) @(negedge clk);
   endtask

   task automatic startCond();
      applyStimulus(1'b1, 1'b1); applyStimulus(1'b1, 1'b0); applyStimulus(1'b0, 1'b0);
   endtask

   task automatic repStart();
      applyStimulus(1'b0, 1'b1); applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0); applyStimulus(1'b0, 1'b0);
   endtask

   task automatic stopCond();
      applyStimulus(1'b0, 1'b0); applyStimulus(1'b1, 1'b0); applyStimulus(1'b1, 1'b1);
   endtask

   task automatic writeBit(input logic b);
      applyStimulus(1'b0, b); applyStimulus(1'b1, b); applyStimulus(1'b1, b); applyStimulus(1'b0, b);
   endtask

   task automatic readBit(output logic b);
      applyStimulus(1'b0, 1'b1); applyStimulus(1'b1, 1'b1);
      b = sdaLine;
      applyStimulus(1'b1, 1'b1); applyStimulus(1'b0, 1'b1);
   endtask

   task automatic writeByte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) writeBit(b[i]);
      readBit(r);
      ack = ~r;
   endtask

   task automatic readByte(output logic [7:0] b, input bit ackIt);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         readBit(r);
         b[i] = r;
      end
      writeBit(ackIt ? 1'b0 : 1'b1);
   endtask

   task automatic modelReset();
      model[0] = 8'h00;
      for (int i = 1; i < NUM_REGS; i++) model[i] = REG_INIT;
      mPtr = 0;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".sda_oe"}, sda_oe, 0);
      checkOutput({tag, ".wr_strobe"}, wr_strobe, 0);
      checkOutput({tag, ".wr_addr"}, wr_addr, 0);
      checkOutput({tag, ".wr_data"}, wr_data, 0);
      checkOutput({tag, ".busy"}, busy, 0);
   endtask

   // Address, pointer and n data bytes; the model decides ACKs and commits.
   task automatic writeTx(input logic [7:0] p, input int n, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input bit doStop);
      logic [7:0] bytes [3];
      logic [7:0] expA [3];
      logic [7:0] expD [3];
      logic       ack, inRange;
      int         s0, k;
      bytes = '{b0, b1, b2};
      s0 = strbCnt;
      k = 0;
      startCond();
      writeByte(8'h90, ack);
      checkOutput("addrAckW", ack, 1);
      writeByte(p, ack);
      inRange = (int'(p) < NUM_REGS);
      checkOutput("ptrAck", ack, inRange);
      if (inRange) mPtr = int'(p);
      for (int i = 0; i < n; i++) begin
         writeByte(bytes[i], ack);
         checkOutput("dataAck", ack, inRange);
         if (inRange) begin
            expA[k] = 8'(mPtr);
            expD[k] = bytes[i];
            k++;
            if (mPtr != 0) model[mPtr] = bytes[i];
            mPtr = (mPtr + 1) % NUM_REGS;
         end
      end
      checkOutput("busyW", busy, 1);
      checkOutput("strobeCount", strbCnt - s0, k);
      for (int j = 0; j < k; j++) begin
         checkOutput("strobeAddr", strbAddr[s0 + j], expA[j]);
         checkOutput("strobeData", strbData[s0 + j], expD[j]);
      end
      if (doStop) begin
         stopCond();
         checkOutput("busyStopW", busy, 0);
      end
   endtask

   task automatic readTx(input int n, input bit rep);
      logic [7:0] b;
      logic       ack;
      int         s0;
      s0 = strbCnt;
      if (rep) repStart(); else startCond();
      writeByte(8'h91, ack);
      checkOutput("addrAckR", ack, 1);
      for (int i = 0; i < n; i++) begin
         readByte(b, i != n - 1);
         checkOutput("rdata", b, model[mPtr]);
         mPtr = (mPtr + 1) % NUM_REGS;
      end
      checkOutput("busyRd", busy, 1);
      checkOutput("noStrobeOnRead", strbCnt - s0, 0);
      stopCond();
      checkOutput("busyStopR", busy, 0);
   endtask

   initial begin
      logic       ack, r;
      int         o0, s0, n;
      logic [7:0] p;
      total = 0; bad = 0; oeCnt = 0; strbCnt = 0;
      rst_n = 1'b0; sclM = 1'b1; sdaM = 1'b1;
      sensor_valid = 1'b0; sensor_data = 8'h00;
      modelReset();
      repeat (5) @(negedge clk);
      checkResetState("reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checkResetState("postReset");

      writeTx(8'h03, 2, 8'hA5, 8'h5A, 8'h00, 1'b1);

      writeTx(8'h03, 0, 8'h00, 8'h00, 8'h00, 1'b0);
      readTx(2, 1'b1);
      readTx(1, 1'b0);

      writeTx(8'h07, 2, 8'h11, 8'h22, 8'h00, 1'b1);
      writeTx(8'h07, 0, 8'h00, 8'h00, 8'h00, 1'b0);
      readTx(3, 1'b1);

      o0 = oeCnt;
      s0 = strbCnt;
      startCond();
      writeByte(8'h92, ack);
      checkOutput("wrongAddrAck", ack, 0);
      checkOutput("wrongAddrBusy", busy, 0);
      writeByte(8'h01, ack);
      checkOutput("wrongAddrData", ack, 0);
      stopCond();
      checkOutput("wrongAddrBusyStop", busy, 0);
      checkOutput("wrongAddrNoDrive", oeCnt - o0, 0);
      checkOutput("wrongAddrNoStrobe", strbCnt - s0, 0);

      writeTx(8'h09, 1, 8'h77, 8'h00, 8'h00, 1'b1);
      readTx(1, 1'b0);

      @(negedge clk);
      sensor_data = 8'h3C;
      sensor_valid = 1'b1;
      @(negedge clk);
      sensor_valid = 1'b0;
      model[0] = 8'h3C;
      writeTx(8'h00, 0, 8'h00, 8'h00, 8'h00, 1'b0);
      readTx(1, 1'b1);

      for (int it = 0; it < 6; it++) begin
         p = 8'($urandom_range(0, 11));
         n = $urandom_range(1, 3);
         writeTx(p, n, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
         p = 8'($urandom_range(0, NUM_REGS - 1));
         writeTx(p, 0, 8'h00, 8'h00, 8'h00, 1'b0);
         readTx($urandom_range(1, 4), 1'b1);
      end

      writeTx(8'h02, 1, 8'h00, 8'h00, 8'h00, 1'b1);
      writeTx(8'h02, 0, 8'h00, 8'h00, 8'h00, 1'b0);
      repStart();
      writeByte(8'h91, ack);
      checkOutput("addrAckPreReset", ack, 1);
      for (int i = 0; i < 3; i++) readBit(r);
      applyStimulus(1'b0, 1'b1);
      checkOutput("oeBit4", sda_oe, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncRelease", sda_oe, 0);
      checkOutput("asyncBusy", busy, 0);
      repeat (3) @(negedge clk);
      checkResetState("midReset");
      rst_n = 1'b1;
      modelReset();
      stopCond();
      checkResetState("afterMidReset");
      writeTx(8'h06, 1, 8'($urandom), 8'h00, 8'h00, 1'b1);
      writeTx(8'h00, 0, 8'h00, 8'h00, 8'h00, 1'b0);
      readTx(4, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
